// File: rtl/imm_extend_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe_pkg
//   Shared high-level control definitions for the Register-stage immediate path.
//   Holds the immediate-format select enum (including CSR zimm) and a helper
//   giving the shift-amount width for a given XLEN.
// -----------------------------------------------------------------------------
package imm_extend_pipe_pkg;

    // Immediate format select. Encoding 3'd7 is left undefined and is reported
    // as illegal by the decoder.
    typedef enum logic [2:0] {
        IMM_11T0 = 3'd0,
        S_TYPE   = 3'd1,
        B_TYPE   = 3'd2,
        U_TYPE   = 3'd3,
        J_TYPE   = 3'd4,
        IMM_4T0  = 3'd5,
        Z_IMM    = 3'd6
    } imm_src_t;

    localparam int IMM_SRC_W = 3;

    // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
    function automatic int imm_shamt_w(input int xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_select.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe_select  (module imm_select)
//   Purely combinational immediate decode.
//   Ports:
//     instr   in  32    raw instruction word
//     immsrc  in  3     immediate format select (imm_src_t)
//     imm     out XLEN  sign/zero extended immediate
//     illegal out 1     immsrc is not a defined encoding
// -----------------------------------------------------------------------------
module imm_select
    import imm_extend_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_src_t        immsrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam int SHAMT_W = imm_shamt_w(XLEN);

    logic        s;
    logic [63:0] imm64;
    logic        unused_bits;

    assign s = instr[31];

    // Every format is built at 64 bits and then truncated, so the RV32 and
    // RV64 variants share one decode table.
    always_comb begin
        imm64   = '0;
        illegal = 1'b0;
        case (immsrc)
            IMM_11T0: imm64 = {{52{s}}, instr[31:20]};
            S_TYPE:   imm64 = {{52{s}}, instr[31:25], instr[11:7]};
            B_TYPE:   imm64 = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            U_TYPE:   imm64 = {{32{s}}, instr[31:12], 12'b0};
            J_TYPE:   imm64 = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_4T0:  imm64[SHAMT_W-1:0] = instr[20 +: SHAMT_W];
            Z_IMM:    imm64 = {59'b0, instr[19:15]};
            default:  illegal = 1'b1;
        endcase
    end

    assign imm = imm64[XLEN-1:0];

    // Opcode bits and the upper half at XLEN=32 are intentionally unused.
    assign unused_bits = ^{instr[6:0], imm64};

endmodule

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//   Registered immediate generator with a valid/ready handshake. A main
//   register (M) drives the outputs; a skid register (K) catches one extra
//   entry while Execute stalls, so in_ready depends only on state.
//   Ports:
//     clk, reset          clock and asynchronous active-high reset
//     flush               synchronous squash of all held entries
//     in_valid/in_ready   upstream handshake (in_ready = !K.valid)
//     in_instr/in_immsrc  instruction and immediate format select
//     in_tag              sideband tag carried unmodified
//     out_valid/out_ready downstream handshake
//     out_imm/out_tag     immediate and tag of the entry in M
//     out_illegal         immsrc of that entry was undefined
// -----------------------------------------------------------------------------
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  imm_src_t         in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] new_imm;
    logic            new_illegal;

    imm_select #(.XLEN(XLEN)) u_select (
        .instr   (in_instr),
        .immsrc  (in_immsrc),
        .imm     (new_imm),
        .illegal (new_illegal)
    );

    logic             m_valid_q, m_valid_d;
    logic [XLEN-1:0]  m_imm_q,   m_imm_d;
    logic [TAG_W-1:0] m_tag_q,   m_tag_d;
    logic             m_ill_q,   m_ill_d;
    logic             k_valid_q, k_valid_d;
    logic [XLEN-1:0]  k_imm_q,   k_imm_d;
    logic [TAG_W-1:0] k_tag_q,   k_tag_d;
    logic             k_ill_q,   k_ill_d;

    logic accept;
    logic drain;

    assign in_ready = ~k_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = m_valid_q & out_ready;

    // Next-state for M and K in priority order. When K holds an entry
    // in_ready is low, so an accept never coincides with a K->M move.
    always_comb begin
        m_valid_d = m_valid_q;
        m_imm_d   = m_imm_q;
        m_tag_d   = m_tag_q;
        m_ill_d   = m_ill_q;
        k_valid_d = k_valid_q;
        k_imm_d   = k_imm_q;
        k_tag_d   = k_tag_q;
        k_ill_d   = k_ill_q;
        if (flush) begin
            m_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (k_valid_q && drain) begin
            m_valid_d = 1'b1;
            m_imm_d   = k_imm_q;
            m_tag_d   = k_tag_q;
            m_ill_d   = k_ill_q;
            k_valid_d = 1'b0;
        end else if (accept && (!m_valid_q || drain)) begin
            m_valid_d = 1'b1;
            m_imm_d   = new_imm;
            m_tag_d   = in_tag;
            m_ill_d   = new_illegal;
        end else if (accept) begin
            k_valid_d = 1'b1;
            k_imm_d   = new_imm;
            k_tag_d   = in_tag;
            k_ill_d   = new_illegal;
        end else if (drain) begin
            m_valid_d = 1'b0;
        end
    end

    // Data registers are reset too so the outputs read zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_imm_q   <= '0;
            m_tag_q   <= '0;
            m_ill_q   <= 1'b0;
            k_valid_q <= 1'b0;
            k_imm_q   <= '0;
            k_tag_q   <= '0;
            k_ill_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_imm_q   <= m_imm_d;
            m_tag_q   <= m_tag_d;
            m_ill_q   <= m_ill_d;
            k_valid_q <= k_valid_d;
            k_imm_q   <= k_imm_d;
            k_tag_q   <= k_tag_d;
            k_ill_q   <= k_ill_d;
        end
    end

    assign out_valid   = m_valid_q;
    assign out_imm     = m_imm_q;
    assign out_tag     = m_tag_q;
    assign out_illegal = m_ill_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
//   Directed bench driving an XLEN=32 and an XLEN=64 instance from the same
//   inputs, comparing both against hand-computed immediates.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;
    import imm_extend_pipe_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    imm_src_t    in_immsrc;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int n_cmp = 0;
    int n_mis = 0;

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one entry on the input for one cycle; returns at the next
    // negedge, with the entry registered if it was accepted.
    task automatic applyStimulus(input logic [31:0] instr, input imm_src_t src, input logic [4:0] tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_immsrc = src;
        in_tag    = tag;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // One unstalled transfer, checked on both widths one cycle later.
    task automatic sendOne(input string name, input logic [31:0] instr, input imm_src_t src,
                           input logic [4:0] tag, input logic [31:0] exp32,
                           input logic [63:0] exp64, input logic exp_ill);
        applyStimulus(instr, src, tag);
        checkOutput({name, " valid32"}, 64'(out_valid32), 64'd1);
        checkOutput({name, " valid64"}, 64'(out_valid64), 64'd1);
        checkOutput({name, " imm32"}, 64'(out_imm32), 64'(exp32));
        checkOutput({name, " imm64"}, out_imm64, exp64);
        checkOutput({name, " tag"}, 64'(out_tag32), 64'(tag));
        checkOutput({name, " illegal32"}, 64'(out_illegal32), 64'(exp_ill));
        checkOutput({name, " illegal64"}, 64'(out_illegal64), 64'(exp_ill));
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_immsrc = IMM_11T0;
        in_tag    = '0;
        out_ready = 1'b1;

        #3;
        checkOutput("rst valid", 64'(out_valid32 | out_valid64), 64'd0);
        checkOutput("rst imm64", out_imm64, 64'd0);
        checkOutput("rst tag", 64'(out_tag32), 64'd0);
        checkOutput("rst ready", 64'(in_ready32 & in_ready64), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Immediate formats
        sendOne("imm11", 32'hFFF00093, IMM_11T0, 5'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        sendOne("btype", 32'hFE000EE3, B_TYPE,   5'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        sendOne("jtype", 32'h0000006F, J_TYPE,   5'd3, 32'h00000000, 64'h0, 1'b0);
        sendOne("utype", 32'h800000B7, U_TYPE,   5'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        sendOne("shamt", 32'h03F09093, IMM_4T0,  5'd5, 32'd31, 64'd63, 1'b0);
        sendOne("stype", 32'h00112623, S_TYPE,   5'd6, 32'd12, 64'd12, 1'b0);
        sendOne("zimm",  32'h800F8073, Z_IMM,    5'd7, 32'd31, 64'd31, 1'b0);
        sendOne("undef", 32'hFFFFFFFF, imm_src_t'(3'd7), 5'd8, 32'd0, 64'd0, 1'b1);
        @(negedge clk);
        checkOutput("drain empty", 64'(out_valid32), 64'd0);

        // Back-pressure: tags 1,2,3 back to back
        out_ready = 1'b0;
        applyStimulus(32'h00100093, IMM_11T0, 5'd1);
        checkOutput("stall m tag1", 64'(out_tag32), 64'd1);
        in_valid = 1'b1; in_instr = 32'h00200093; in_tag = 5'd2;
        @(negedge clk);
        in_instr = 32'h00300093; in_tag = 5'd3;
        checkOutput("stall ready0", 64'(in_ready32), 64'd0);
        checkOutput("stall hold tag1", 64'(out_tag32), 64'd1);
        @(negedge clk);
        checkOutput("stall stable tag", 64'(out_tag64), 64'd1);
        checkOutput("stall stable imm", out_imm64, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("drain tag2", 64'(out_tag32), 64'd2);
        checkOutput("drain imm2", 64'(out_imm32), 64'd2);
        checkOutput("drain ready1", 64'(in_ready32), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("drain tag3", 64'(out_tag32), 64'd3);
        checkOutput("drain valid3", 64'(out_valid32), 64'd1);
        @(negedge clk);
        checkOutput("drain done", 64'(out_valid32), 64'd0);

        // Flush with M and K full and an input presented
        out_ready = 1'b0;
        applyStimulus(32'h00400093, IMM_11T0, 5'd4);
        applyStimulus(32'h00500093, IMM_11T0, 5'd5);
        checkOutput("full ready0", 64'(in_ready32), 64'd0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd6;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush valid", 64'(out_valid32 | out_valid64), 64'd0);
        checkOutput("flush ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("flush absent", 64'(out_valid32), 64'd0);

        // Flush while in_ready=1: the same-cycle input must be dropped
        out_ready = 1'b0;
        applyStimulus(32'h00700093, IMM_11T0, 5'd7);
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd8;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("flush drop valid", 64'(out_valid32), 64'd0);
        checkOutput("flush drop ready", 64'(in_ready64), 64'd1);

        // Asynchronous reset in the middle of a stall
        applyStimulus(32'hFFF00093, IMM_11T0, 5'd9);
        applyStimulus(32'hFFF00093, imm_src_t'(3'd7), 5'd10);
        checkOutput("pre-rst valid", 64'(out_valid32), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async valid", 64'(out_valid32 | out_valid64), 64'd0);
        checkOutput("async imm", out_imm64 | 64'(out_imm32), 64'd0);
        checkOutput("async tag", 64'(out_tag32 | out_tag64), 64'd0);
        checkOutput("async illegal", 64'(out_illegal32 | out_illegal64), 64'd0);
        checkOutput("async ready", 64'(in_ready32 & in_ready64), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post-rst empty", 64'(out_valid32), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
